l1_mem_arbiter: RTL and testbench

L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

---
 rtl/l1_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1_mem_arbiter
//
// Purpose: shares one memory port between the icache controller (read-only)
// and the dcache controller (refill reads and write-backs). Only one
// transaction is in flight at a time. The owner is shown by a one-hot grant.
// Each grant covers exactly one transaction and then returns to IDLE for at
// least one cycle.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// round-robin. The winner is the requester that was not served most recently.
// Without the macro the dcache always wins a tie.
//
// Handshake: every request (iRen, dRen, dWen) is a level. The requester holds
// it until the matching single-cycle completion pulse comes back. The
// memory-side requests stay asserted while the owner holds its request. A
// memory completion pulse (memReadReady / memWriteDone) ends the transaction.
// The pulse is forwarded in the same cycle to the owner only.
//
// Ports:
//   clock, reset        : single clock; asynchronous active-low reset
//   iRen, iAddr         : icache read request and block address
//   iReadReady          : icache completion pulse
//   dRen, dWen          : dcache read / write-back request; both high = invalid
//   dAddr, dDin         : dcache block address and write-back data
//   dReadReady          : dcache read completion pulse
//   dWriteDone          : dcache write completion pulse
//   memRen, memWen      : requests to the shared memory
//   memAddr, memDin     : memory address and write data
//   memReadReady        : memory read completion pulse
//   memWriteDone        : memory write completion pulse
//   memDout             : memory read data
//   rdData              : read data passed unchanged to both caches
//   grant               : one-hot owner; bit0 = icache, bit1 = dcache, 00 = idle
//   dbg_state           : FSM state for observation (0 IDLE, 1 GNT_I, 2 GNT_D)
// -----------------------------------------------------------------------------
module l1_mem_arbiter #(
  parameter int BADDR_W = 28,
  parameter int BLOCK_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  // icache side
  input  logic               iRen,
  input  logic [BADDR_W-1:0] iAddr,
  output logic               iReadReady,
  // dcache side
  input  logic               dRen,
  input  logic               dWen,
  input  logic [BADDR_W-1:0] dAddr,
  input  logic [BLOCK_W-1:0] dDin,
  output logic               dReadReady,
  output logic               dWriteDone,
  // memory side
  output logic               memRen,
  output logic               memWen,
  output logic [BADDR_W-1:0] memAddr,
  output logic [BLOCK_W-1:0] memDin,
  input  logic               memReadReady,
  input  logic               memWriteDone,
  input  logic [BLOCK_W-1:0] memDout,
  output logic [BLOCK_W-1:0] rdData,
  // status
  output logic [1:0]         grant,
  output logic [1:0]         dbg_state
);

  // The encoding matches the grant bits: GNT_I = 01, GNT_D = 10.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Records whether the dcache grant is a write-back (1) or a refill (0).
  // If the dcache switches request type mid-grant, that counts as dropping
  // the current request. A write-back followed by a refill therefore always
  // becomes two separate transactions.
  logic d_wr_q, d_wr_d;

  logic i_req;
  logic d_req;
  logic d_hold;
  logic pick_i;
  logic pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 0: the icache has priority on the next tie. 1: the dcache has priority.
  logic rr_ptr_q, rr_ptr_d;
`endif

  assign i_req  = iRen;
  assign d_req  = dRen ^ dWen;
  assign d_hold = d_req && (dWen == d_wr_q);

  // Arbitration between the two requesters while in IDLE.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (i_req && !d_req) begin
      pick_i = 1'b1;
    end else if (d_req && !i_req) begin
      pick_d = 1'b1;
    end else if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_i = ~rr_ptr_q;
      pick_d = rr_ptr_q;
`else
      pick_d = 1'b1;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    d_wr_d  = d_wr_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d = GNT_I;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d = 1'b1;
`endif
        end else if (pick_d) begin
          state_d = GNT_D;
          d_wr_d  = dWen;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d = 1'b0;
`endif
        end
      end
      GNT_I: begin
        if (!iRen || memReadReady) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        if (!d_hold || memReadReady || memWriteDone) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      d_wr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_wr_q  <= d_wr_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Output logic. The outputs are a combinational function of the owner's
  // request. Reset forces state_q to IDLE asynchronously, so every
  // state-derived output drops to zero as soon as reset goes low.
  always_comb begin
    memRen     = 1'b0;
    memWen     = 1'b0;
    memAddr    = '0;
    memDin     = '0;
    iReadReady = 1'b0;
    dReadReady = 1'b0;
    dWriteDone = 1'b0;
    grant      = 2'b00;
    case (state_q)
      GNT_I: begin
        grant      = 2'b01;
        memRen     = iRen;
        memAddr    = iAddr;
        iReadReady = memReadReady;
      end
      GNT_D: begin
        grant      = 2'b10;
        memRen     = d_hold && !d_wr_q;
        memWen     = d_hold && d_wr_q;
        memAddr    = dAddr;
        memDin     = dDin;
        dReadReady = memReadReady;
        dWriteDone = memWriteDone;
      end
      default: begin
      end
    endcase
  end

  // Read data is not tied to ownership, but it is held at zero during reset.
  assign rdData    = reset ? memDout : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l1_mem_arbiter
//
// Directed bench for l1_mem_arbiter. Inputs change 1 time unit after the
// rising edge. Outputs are sampled on the falling edge.
// Define ARB_ROUND_ROBIN_EN for both the DUT and the bench to check the
// round-robin build.
// -----------------------------------------------------------------------------
module tb_l1_mem_arbiter;

  localparam int BADDR_W = 28;
  localparam int BLOCK_W = 128;

  logic               clock;
  logic               reset;
  logic               iRen;
  logic [BADDR_W-1:0] iAddr;
  logic               iReadReady;
  logic               dRen;
  logic               dWen;
  logic [BADDR_W-1:0] dAddr;
  logic [BLOCK_W-1:0] dDin;
  logic               dReadReady;
  logic               dWriteDone;
  logic               memRen;
  logic               memWen;
  logic [BADDR_W-1:0] memAddr;
  logic [BLOCK_W-1:0] memDin;
  logic               memReadReady;
  logic               memWriteDone;
  logic [BLOCK_W-1:0] memDout;
  logic [BLOCK_W-1:0] rdData;
  logic [1:0]         grant;
  logic [1:0]         dbg_state;

  int total;
  int bad;

  localparam logic [BADDR_W-1:0] I_ADDR  = 28'h0000010;
  localparam logic [BADDR_W-1:0] D_ADDR  = 28'h0ABCDEF;
  localparam logic [BLOCK_W-1:0] D_DATA  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [BLOCK_W-1:0] RD_DATA = 128'hCAFEF00D_DEADBEEF_12345678_9ABCDEF0;

  l1_mem_arbiter #(
    .BADDR_W(BADDR_W),
    .BLOCK_W(BLOCK_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iRen        (iRen),
    .iAddr       (iAddr),
    .iReadReady  (iReadReady),
    .dRen        (dRen),
    .dWen        (dWen),
    .dAddr       (dAddr),
    .dDin        (dDin),
    .dReadReady  (dReadReady),
    .dWriteDone  (dWriteDone),
    .memRen      (memRen),
    .memWen      (memWen),
    .memAddr     (memAddr),
    .memDin      (memDin),
    .memReadReady(memReadReady),
    .memWriteDone(memWriteDone),
    .memDout     (memDout),
    .rdData      (rdData),
    .grant       (grant),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // checker
  task automatic check_eq(input string tag, input logic [BLOCK_W-1:0] obs,
                          input logic [BLOCK_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".grant"}, grant, 2'b00);
    check_eq({tag, ".memRen"}, memRen, 1'b0);
    check_eq({tag, ".memWen"}, memWen, 1'b0);
    check_eq({tag, ".memAddr"}, memAddr, '0);
    check_eq({tag, ".memDin"}, memDin, '0);
  endtask

  task automatic check_no_done(input string tag);
    check_eq({tag, ".iReadReady"}, iReadReady, 1'b0);
    check_eq({tag, ".dReadReady"}, dReadReady, 1'b0);
    check_eq({tag, ".dWriteDone"}, dWriteDone, 1'b0);
  endtask

  // icache read: the grant is already held. Check the owner view, pulse
  // completion, then drop the request.
  task automatic serve_icache(input string tag);
    sample();
    check_eq({tag, ".grant"}, grant, 2'b01);
    check_eq({tag, ".memRen"}, memRen, 1'b1);
    check_eq({tag, ".memWen"}, memWen, 1'b0);
    check_eq({tag, ".memAddr"}, memAddr, I_ADDR);
    check_eq({tag, ".memDin"}, memDin, '0);
    tick();
    memReadReady = 1'b1;
    memDout      = RD_DATA;
    sample();
    check_eq({tag, ".iReadReady"}, iReadReady, 1'b1);
    check_eq({tag, ".dReadReady"}, dReadReady, 1'b0);
    check_eq({tag, ".rdData"}, rdData, RD_DATA);
    tick();
    memReadReady = 1'b0;
    iRen         = 1'b0;
  endtask

  task automatic serve_dread(input string tag);
    sample();
    check_eq({tag, ".grant"}, grant, 2'b10);
    check_eq({tag, ".memRen"}, memRen, 1'b1);
    check_eq({tag, ".memWen"}, memWen, 1'b0);
    check_eq({tag, ".memAddr"}, memAddr, D_ADDR);
    tick();
    memReadReady = 1'b1;
    memDout      = RD_DATA;
    sample();
    check_eq({tag, ".dReadReady"}, dReadReady, 1'b1);
    check_eq({tag, ".iReadReady"}, iReadReady, 1'b0);
    tick();
    memReadReady = 1'b0;
    dRen         = 1'b0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    iRen         = 1'b0;
    iAddr        = '0;
    dRen         = 1'b0;
    dWen         = 1'b0;
    dAddr        = '0;
    dDin         = '0;
    memReadReady = 1'b0;
    memWriteDone = 1'b0;
    memDout      = '0;

    // Reset state
    sample();
    check_idle_outputs("reset");
    check_no_done("reset");
    check_eq("reset.rdData", rdData, '0);
    tick();
    reset = 1'b1;
    sample();
    check_idle_outputs("post_reset");

    // icache read alone
    tick();
    iRen  = 1'b1;
    iAddr = I_ADDR;
    sample();
    check_idle_outputs("i_lat0");
    tick();
    serve_icache("i_read");
    sample();
    check_idle_outputs("i_after");
    check_no_done("i_after");

    // dcache write-back
    tick();
    dWen  = 1'b1;
    dAddr = D_ADDR;
    dDin  = D_DATA;
    tick();
    sample();
    check_eq("d_wr.grant", grant, 2'b10);
    check_eq("d_wr.memWen", memWen, 1'b1);
    check_eq("d_wr.memRen", memRen, 1'b0);
    check_eq("d_wr.memAddr", memAddr, D_ADDR);
    check_eq("d_wr.memDin", memDin, D_DATA);
    tick();
    memWriteDone = 1'b1;
    sample();
    check_eq("d_wr.dWriteDone", dWriteDone, 1'b1);
    check_eq("d_wr.iReadReady", iReadReady, 1'b0);
    // A refill follows immediately and must be a separate grant.
    tick();
    memWriteDone = 1'b0;
    dWen         = 1'b0;
    dRen         = 1'b1;
    sample();
    check_idle_outputs("wb_gap");
    tick();
    serve_dread("refill");
    sample();
    check_idle_outputs("refill_after");

    // Simultaneous requests. The previous owner was the dcache.
    tick();
    iRen  = 1'b1;
    iAddr = I_ADDR;
    dRen  = 1'b1;
    dAddr = D_ADDR;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    serve_icache("tie_first_i");
    sample();
    check_idle_outputs("tie_gap");
    tick();
    serve_dread("tie_second_d");
`else
    serve_dread("tie_first_d");
    sample();
    check_idle_outputs("tie_gap");
    tick();
    serve_icache("tie_second_i");
`endif
    sample();
    check_idle_outputs("tie_after");

    // Invalid dcache request (both bits high) is ignored. A concurrent iRen
    // still wins.
    tick();
    dRen = 1'b1;
    dWen = 1'b1;
    tick();
    sample();
    check_idle_outputs("d_both");
    tick();
    iRen = 1'b1;
    tick();
    serve_icache("d_both_i");
    dRen = 1'b0;
    dWen = 1'b0;

    // Completion pulse while idle is ignored.
    tick();
    memReadReady = 1'b1;
    memWriteDone = 1'b1;
    sample();
    check_no_done("idle_done");
    tick();
    memReadReady = 1'b0;
    memWriteDone = 1'b0;
    sample();
    check_idle_outputs("idle_done_after");

    // The owner drops its request before completion.
    tick();
    dRen = 1'b1;
    tick();
    sample();
    check_eq("drop.grant", grant, 2'b10);
    tick();
    dRen = 1'b0;
    sample();
    check_eq("drop.memRen", memRen, 1'b0);
    tick();
    sample();
    check_idle_outputs("drop_after");

    // Reset in the middle of a dcache read
    tick();
    dRen = 1'b1;
    tick();
    sample();
    check_eq("rst_mid.grant_pre", grant, 2'b10);
    check_eq("rst_mid.memRen_pre", memRen, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    memReadReady = 1'b1;
    memDout      = RD_DATA;
    #1;
    check_no_done("rst_mid");
    check_eq("rst_mid.rdData", rdData, '0);
    tick();
    memReadReady = 1'b0;
    reset        = 1'b1;
    sample();
    check_idle_outputs("rst_release");
    // The first edge after release evaluates the held dRen as in IDLE.
    tick();
    serve_dread("rst_regrant");
    sample();
    check_idle_outputs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
